button_event: RTL and testbench
===============================

Name: button_event

Overview:
- Consumer end of the button-conditioning path. Takes a clean, debounced button level and turns it into discrete events: PRESS, RELEASE, LONG (held past a threshold) and REPEAT (auto-repeat while held).
- Events leave through a single-entry valid/ready buffer with sticky overflow detection.
- Sits between the per-button debouncers and the OLED demo control logic, or any CPU-visible input register.

Parameters:
- HOLD_CYCLES, 50000000: cycles the button must stay held after PRESS before LONG is emitted; must be >= 1.
- REPEAT_CYCLES, 10000000: period of REPEAT events after LONG; 0 disables REPEAT.
- CNT_W, 26: counter width; must hold max(HOLD_CYCLES, REPEAT_CYCLES) - 1.

Ports:
- clk, input, 1: sole clock; all logic is on posedge.
- rst, input, 1: asynchronous, active-high reset.
- btn, input, 1: debounced button level, synchronous to clk; 1 = pressed.
- held, output, 1: 1 while the FSM is in PRESSED or LONG.
- ev_valid, output, 1: event buffer holds an event.
- ev_code, output, 2: event code. 00 = PRESS, 01 = RELEASE, 10 = LONG, 11 = REPEAT.
- ev_ready, input, 1: consumer accepts the event; transfer occurs when ev_valid && ev_ready at a posedge.
- ovf, output, 1: sticky flag; an event was dropped because the buffer was full.
- ovf_clr, input, 1: clears ovf.

Behaviour:
- Reset (async assert, applied immediately): state = IDLE, count = 0, held = 0, ev_valid = 0, ev_code = 00, ovf = 0.
- FSM states: IDLE, PRESSED, LONG. Evaluated each posedge.
  - IDLE, btn = 1: go to PRESSED, count <= 0, generate PRESS.
  - IDLE, btn = 0: stay in IDLE.
  - PRESSED, btn = 0: go to IDLE, generate RELEASE.
  - PRESSED, btn = 1 and count == HOLD_CYCLES-1: go to LONG, count <= 0, generate LONG.
  - PRESSED, btn = 1 otherwise: count <= count + 1.
  - LONG, btn = 0: go to IDLE, generate RELEASE.
  - LONG, btn = 1, REPEAT_CYCLES != 0 and count == REPEAT_CYCLES-1: count <= 0, generate REPEAT.
  - LONG, btn = 1 otherwise: count <= count + 1, saturating when REPEAT_CYCLES == 0.
- Priority: btn = 0 beats any threshold match in the same cycle, so only RELEASE is emitted.
- Timing:
  - PRESS is visible on ev_valid/ev_code the cycle after the first posedge that samples btn = 1 (1-cycle latency).
  - LONG appears exactly HOLD_CYCLES cycles after PRESS.
  - The first REPEAT appears REPEAT_CYCLES cycles after LONG, then every REPEAT_CYCLES cycles after that.
- held is registered and updates on the same edge as the state change.
- Event buffer, at most one event generated per cycle:
  - Empty, or being drained this cycle (ev_valid && ev_ready): a new event is loaded and ev_valid stays or becomes 1.
  - Full and not drained: the new event is dropped, the held event is unchanged and ovf <= 1.
  - Drained with no new event: ev_valid <= 0. ev_code holds its last value.
  - ev_code and ev_valid are stable while ev_valid && !ev_ready.
- ovf_clr and a new drop in the same cycle: ovf stays 1 (set wins).
- Reset while btn = 1: after reset releases, IDLE samples btn = 1 and emits PRESS. No RELEASE is emitted for the interrupted press.
- Counter arithmetic: unsigned CNT_W bits, never wraps. It is always cleared at a threshold match or on state entry.

Test Plan (HOLD_CYCLES = 8, REPEAT_CYCLES = 4, ev_ready = 1 unless noted):
- Short press: btn high for 3 cycles, then low -> PRESS (00) one cycle after rise; RELEASE (01) one cycle after fall; no LONG; held high for 3 cycles.
- Long press with repeat: btn held for 20 cycles -> PRESS at t; LONG (10) at t+8; REPEAT (11) at t+12, t+16 and t+20 (if still held); RELEASE after fall.
- Release on threshold cycle: btn drops on the exact cycle count == 7 -> only RELEASE is emitted, state returns to IDLE, no LONG.
- Backpressure: ev_ready = 0 across PRESS then RELEASE -> ev_code stays 00 with ev_valid = 1, RELEASE is dropped, ovf = 1. Then ev_ready = 1 -> PRESS is consumed and ev_valid drops. Then ovf_clr -> ovf = 0.
- Drain and load in the same cycle: ev_ready pulses on the same cycle LONG is generated while PRESS is pending -> PRESS is consumed, ev_code becomes 10, ev_valid stays 1, ovf stays 0.
- Async reset mid-LONG with btn held -> outputs reset immediately; after release, PRESS is emitted and LONG follows 8 cycles later.

Source files
------------

// File: rtl/button_event.sv
// button_event: turns a debounced button level into PRESS / RELEASE / LONG /
// REPEAT events, delivered through a single-entry valid/ready buffer with a
// sticky overflow flag.
module button_event #(
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       held,
  output logic       ev_valid,
  output logic [1:0] ev_code,
  input  logic       ev_ready,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_LONG    = 2'b10;
  localparam logic [1:0] EV_REPEAT  = 2'b11;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam bit               REPEAT_EN   = (REPEAT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             gen;
  logic [1:0]       gen_code;
  logic             drain;
  logic             load;
  logic             drop;

  // State and hold/repeat counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state and counter update; a released button always wins over a threshold
  always_comb begin
    state_next = state;
    count_next = count;
    unique case (state)
      ST_IDLE: begin
        if (btn) begin
          state_next = ST_PRESSED;
          count_next = '0;
        end
      end
      ST_PRESSED: begin
        if (!btn) begin
          state_next = ST_IDLE;
          count_next = '0;
        end else if (count == HOLD_LAST) begin
          state_next = ST_LONG;
          count_next = '0;
        end else begin
          count_next = count + CNT_W'(1);
        end
      end
      ST_LONG: begin
        if (!btn) begin
          state_next = ST_IDLE;
          count_next = '0;
        end else if (REPEAT_EN && (count == REPEAT_LAST)) begin
          count_next = '0;
        end else if (count != CNT_MAX) begin
          count_next = count + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  // Event generation for the current transition (at most one per cycle)
  always_comb begin
    gen      = 1'b0;
    gen_code = EV_PRESS;
    unique case (state)
      ST_IDLE: begin
        if (btn) begin
          gen      = 1'b1;
          gen_code = EV_PRESS;
        end
      end
      ST_PRESSED: begin
        if (!btn) begin
          gen      = 1'b1;
          gen_code = EV_RELEASE;
        end else if (count == HOLD_LAST) begin
          gen      = 1'b1;
          gen_code = EV_LONG;
        end
      end
      ST_LONG: begin
        if (!btn) begin
          gen      = 1'b1;
          gen_code = EV_RELEASE;
        end else if (REPEAT_EN && (count == REPEAT_LAST)) begin
          gen      = 1'b1;
          gen_code = EV_REPEAT;
        end
      end
      default: begin
        gen      = 1'b0;
        gen_code = EV_PRESS;
      end
    endcase
  end

  assign drain = ev_valid && ev_ready;
  assign load  = gen && (!ev_valid || ev_ready);
  assign drop  = gen && ev_valid && !ev_ready;

  // Event buffer, held flag and sticky overflow (a drop beats a clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held     <= 1'b0;
      ev_valid <= 1'b0;
      ev_code  <= EV_PRESS;
      ovf      <= 1'b0;
    end else begin
      held <= (state_next != ST_IDLE);
      if (load) begin
        ev_valid <= 1'b1;
        ev_code  <= gen_code;
      end else if (drain) begin
        ev_valid <= 1'b0;
      end
      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event.sv
// tb_button_event: directed scenarios plus randomized stimulus for button_event,
// checked every cycle against a press-duration based reference model.
module tb_button_event;

  localparam int unsigned HOLD   = 8;
  localparam int unsigned REPEAT = 4;
  localparam int unsigned CW     = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn = 1'b0;
  logic       held;
  logic       ev_valid;
  logic [1:0] ev_code;
  logic       ev_ready = 1'b1;
  logic       ovf;
  logic       ovf_clr = 1'b0;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  button_event #(
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REPEAT),
    .CNT_W        (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .held    (held),
    .ev_valid(ev_valid),
    .ev_code (ev_code),
    .ev_ready(ev_ready),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else
      passes++;
  endtask

  // Reference model: time since press decides LONG/REPEAT; buffer is a 1-deep slot
  bit         m_pressed = 1'b0;
  int         m_t = 0;
  bit         m_valid = 1'b0;
  logic [1:0] m_code = 2'b00;
  bit         m_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    bit         gen;
    logic [1:0] code;
    bit         drop;
    if (rst) begin
      m_pressed = 1'b0;
      m_t       = 0;
      m_valid   = 1'b0;
      m_code    = 2'b00;
      m_ovf     = 1'b0;
    end else begin
      gen  = 1'b0;
      code = 2'b00;
      drop = 1'b0;
      if (!m_pressed) begin
        if (btn) begin
          m_pressed = 1'b1;
          m_t       = 0;
          gen       = 1'b1;
          code      = 2'b00;
        end
      end else if (!btn) begin
        m_pressed = 1'b0;
        gen       = 1'b1;
        code      = 2'b01;
      end else begin
        m_t = m_t + 1;
        if (m_t == int'(HOLD)) begin
          gen  = 1'b1;
          code = 2'b10;
        end else if (REPEAT != 0 && m_t > int'(HOLD) && ((m_t - int'(HOLD)) % int'(REPEAT)) == 0) begin
          gen  = 1'b1;
          code = 2'b11;
        end
      end
      if (m_valid && ev_ready) m_valid = 1'b0;
      if (gen) begin
        if (!m_valid) begin
          m_valid = 1'b1;
          m_code  = code;
        end else begin
          drop = 1'b1;
        end
      end
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("held", 32'(held), 32'(m_pressed));
      check("ev_valid", 32'(ev_valid), 32'(m_valid));
      check("ev_code", 32'(ev_code), 32'(m_code));
      check("ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    tick(2);
    check("reset_held", 32'(held), 0);
    check("reset_valid", 32'(ev_valid), 0);
    check("reset_code", 32'(ev_code), 0);
    check("reset_ovf", 32'(ovf), 0);
    rst = 1'b0;
    cmp_en = 1'b1;
    tick(2);

    // Short press
    btn = 1'b1;
    tick(1);
    check("short_press_valid", 32'(ev_valid), 1);
    check("short_press_code", 32'(ev_code), 0);
    check("short_press_held", 32'(held), 1);
    tick(2);
    btn = 1'b0;
    tick(1);
    check("short_release_valid", 32'(ev_valid), 1);
    check("short_release_code", 32'(ev_code), 1);
    check("short_release_held", 32'(held), 0);
    tick(3);

    // Long press with repeats
    btn = 1'b1;
    tick(1);
    check("long_press_code", 32'(ev_code), 0);
    tick(7);
    check("long_not_yet", 32'(ev_valid), 0);
    tick(1);
    check("long_valid", 32'(ev_valid), 1);
    check("long_code", 32'(ev_code), 2);
    tick(4);
    check("repeat1_code", 32'(ev_code), 3);
    check("repeat1_valid", 32'(ev_valid), 1);
    tick(4);
    check("repeat2_code", 32'(ev_code), 3);
    tick(4);
    btn = 1'b0;
    tick(1);
    check("long_release_code", 32'(ev_code), 1);
    check("long_release_held", 32'(held), 0);
    tick(3);

    // Release on the threshold cycle
    btn = 1'b1;
    tick(1);
    tick(7);
    btn = 1'b0;
    tick(1);
    check("thr_release_code", 32'(ev_code), 1);
    check("thr_release_held", 32'(held), 0);
    tick(2);
    check("thr_no_long", 32'(ev_valid), 0);
    tick(2);

    // Backpressure with overflow
    ev_ready = 1'b0;
    btn = 1'b1;
    tick(1);
    btn = 1'b0;
    tick(1);
    check("bp_code", 32'(ev_code), 0);
    check("bp_valid", 32'(ev_valid), 1);
    check("bp_ovf", 32'(ovf), 1);
    tick(2);
    ev_ready = 1'b1;
    tick(1);
    check("bp_drained", 32'(ev_valid), 0);
    check("bp_ovf_sticky", 32'(ovf), 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("bp_ovf_clr", 32'(ovf), 0);
    tick(2);

    // Drain and load in the same cycle
    ev_ready = 1'b0;
    btn = 1'b1;
    tick(1);
    tick(7);
    check("dl_pending", 32'(ev_code), 0);
    ev_ready = 1'b1;
    tick(1);
    check("dl_code", 32'(ev_code), 2);
    check("dl_valid", 32'(ev_valid), 1);
    check("dl_ovf", 32'(ovf), 0);
    btn = 1'b0;
    tick(3);

    // Async reset mid-LONG with button held
    btn = 1'b1;
    tick(10);
    #2;
    rst = 1'b1;
    #1;
    check("ar_held", 32'(held), 0);
    check("ar_valid", 32'(ev_valid), 0);
    check("ar_code", 32'(ev_code), 0);
    check("ar_ovf", 32'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    check("ar_press_valid", 32'(ev_valid), 1);
    check("ar_press_code", 32'(ev_code), 0);
    tick(8);
    check("ar_long_code", 32'(ev_code), 2);
    btn = 1'b0;
    tick(2);

    // Randomized stimulus
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) btn = ~btn;
      ev_ready = ($urandom_range(0, 3) != 0);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
      tick(1);
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
